// File: rtl/spi_flash_cmd_seq.sv
// Sequences one SPI-flash transaction (CS, opcode, address, write and read payload)
// over a byte-wide SPI shift engine; owns flash chip select.
module spi_flash_cmd_seq #(
  parameter int unsigned ADDR_BYTES = 3,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned CS_GAP     = 4,
  parameter int unsigned BSY_TO     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       opcode,
  input  logic [31:0]      addr,
  input  logic             use_addr,
  input  logic [LEN_W-1:0] wr_len,
  input  logic [LEN_W-1:0] rd_len,
  input  logic [7:0]       wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             done,
  output logic             err,
  output logic             cs_n,
  output logic             spi_start,
  output logic [7:0]       spi_din,
  input  logic             spi_bsy,
  input  logic [7:0]       spi_dout
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned GW = $clog2(CS_GAP + 1);
  localparam int unsigned TW = $clog2(BSY_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_OPC, S_ADDR, S_WR, S_RD, S_CS_HOLD, S_DONE
  } state_t;

  typedef enum logic [1:0] {B_ISSUE, B_WAIT_HI, B_WAIT_LO} bstate_t;

  state_t           state_q, state_d;
  bstate_t          bst_q, bst_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [TW-1:0]    to_q, to_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [31:0]      addr_q, addr_d;
  logic             use_addr_q, use_addr_d;
  logic [LEN_W-1:0] wr_len_q, wr_len_d, rd_len_q, rd_len_d;
  logic             cmd_ready_d, cs_n_d, spi_start_d, rdata_valid_d, done_d, err_d;
  logic [7:0]       spi_din_d, rdata_d;
  logic             byte_done;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bst_q       <= B_ISSUE;
      gap_q       <= '0;
      to_q        <= '0;
      cnt_q       <= '0;
      opcode_q    <= '0;
      addr_q      <= '0;
      use_addr_q  <= 1'b0;
      wr_len_q    <= '0;
      rd_len_q    <= '0;
      cmd_ready   <= 1'b0;
      cs_n        <= 1'b1;
      spi_start   <= 1'b0;
      spi_din     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      bst_q       <= bst_d;
      gap_q       <= gap_d;
      to_q        <= to_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      use_addr_q  <= use_addr_d;
      wr_len_q    <= wr_len_d;
      rd_len_q    <= rd_len_d;
      cmd_ready   <= cmd_ready_d;
      cs_n        <= cs_n_d;
      spi_start   <= spi_start_d;
      spi_din     <= spi_din_d;
      rdata       <= rdata_d;
      rdata_valid <= rdata_valid_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

  // Next-state and output logic; wdata_ready must qualify the same-cycle wdata
  always_comb begin
    state_d       = state_q;
    bst_d         = bst_q;
    gap_d         = gap_q;
    to_d          = to_q;
    cnt_d         = cnt_q;
    opcode_d      = opcode_q;
    addr_d        = addr_q;
    use_addr_d    = use_addr_q;
    wr_len_d      = wr_len_q;
    rd_len_d      = rd_len_q;
    cs_n_d        = cs_n;
    spi_din_d     = spi_din;
    rdata_d       = rdata;
    err_d         = err;
    spi_start_d   = 1'b0;
    rdata_valid_d = 1'b0;
    wdata_ready   = 1'b0;
    byte_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          opcode_d   = opcode;
          addr_d     = addr;
          use_addr_d = use_addr;
          wr_len_d   = wr_len;
          rd_len_d   = rd_len;
          err_d      = 1'b0;
          cs_n_d     = 1'b0;
          gap_d      = '0;
          cnt_d      = '0;
          bst_d      = B_ISSUE;
          state_d    = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        if (gap_q == GW'(CS_GAP - 1)) begin
          gap_d   = '0;
          state_d = S_OPC;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_OPC, S_ADDR, S_WR, S_RD: begin
        case (bst_q)
          B_ISSUE: begin
            if (!spi_bsy && (state_q != S_WR || wdata_valid)) begin
              spi_start_d = 1'b1;
              to_d        = '0;
              bst_d       = B_WAIT_HI;
              case (state_q)
                S_OPC:   spi_din_d = opcode_q;
                S_ADDR:  spi_din_d = addr_q[AW-1 -: 8];
                S_WR: begin
                  spi_din_d   = wdata;
                  wdata_ready = 1'b1;
                end
                default: spi_din_d = 8'hFF;
              endcase
            end
          end
          B_WAIT_HI: begin
            if (spi_bsy) begin
              bst_d = B_WAIT_LO;
            end else if (to_q == TW'(BSY_TO - 1)) begin
              // Engine never acknowledged: abandon remaining bytes
              err_d   = 1'b1;
              bst_d   = B_ISSUE;
              gap_d   = '0;
              cnt_d   = '0;
              state_d = S_CS_HOLD;
            end else begin
              to_d = to_q + TW'(1);
            end
          end
          B_WAIT_LO: begin
            if (!spi_bsy) begin
              byte_done = 1'b1;
              bst_d     = B_ISSUE;
            end
          end
          default: bst_d = B_ISSUE;
        endcase

        if (byte_done) begin
          if (state_q == S_RD) begin
            rdata_d       = spi_dout;
            rdata_valid_d = 1'b1;
          end
          if (state_q == S_ADDR) addr_d = addr_q << 8;
          cnt_d = cnt_q - LEN_W'(1);
          // Phase finished: pick the next non-empty phase
          if (state_q == S_OPC || cnt_q == LEN_W'(1)) begin
            if (state_q == S_OPC && use_addr_q) begin
              state_d = S_ADDR;
              cnt_d   = LEN_W'(ADDR_BYTES);
            end else if ((state_q == S_OPC || state_q == S_ADDR) && wr_len_q != '0) begin
              state_d = S_WR;
              cnt_d   = wr_len_q;
            end else if (state_q != S_RD && rd_len_q != '0) begin
              state_d = S_RD;
              cnt_d   = rd_len_q;
            end else begin
              state_d = S_CS_HOLD;
              gap_d   = '0;
              cnt_d   = '0;
            end
          end
        end
      end
      S_CS_HOLD: begin
        if (gap_q == GW'(CS_GAP - 1)) begin
          gap_d   = '0;
          cs_n_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_spi_flash_cmd_seq.sv
// Scoreboard bench for spi_flash_cmd_seq: a byte-engine model, a transaction-level
// reference model filling expectation queues, and negedge monitors that pop and compare.
module tb_spi_flash_cmd_seq;

  localparam int ADDR_BYTES = 3;
  localparam int LEN_W      = 16;
  localparam int CS_GAP     = 4;
  localparam int BSY_TO     = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       opcode;
  logic [31:0]      addr;
  logic             use_addr;
  logic [LEN_W-1:0] wr_len;
  logic [LEN_W-1:0] rd_len;
  logic [7:0]       wdata;
  logic             wdata_valid;
  logic             wdata_ready;
  logic [7:0]       rdata;
  logic             rdata_valid;
  logic             done;
  logic             err;
  logic             cs_n;
  logic             spi_start;
  logic [7:0]       spi_din;
  logic             spi_bsy;
  logic [7:0]       spi_dout;

  spi_flash_cmd_seq #(
    .ADDR_BYTES(ADDR_BYTES), .LEN_W(LEN_W), .CS_GAP(CS_GAP), .BSY_TO(BSY_TO)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .opcode(opcode), .addr(addr), .use_addr(use_addr), .wr_len(wr_len), .rd_len(rd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err), .cs_n(cs_n),
    .spi_start(spi_start), .spi_din(spi_din), .spi_bsy(spi_bsy), .spi_dout(spi_dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rdata[$];
  logic [7:0] miso_plan[$];
  logic [7:0] wq[$];
  bit         exp_err[$];

  int   cyc = 0;
  int   start_cyc = 0, fall_cyc = 0, last_end_cyc = 0;
  int   falls = 0, rises = 0, done_seen = 0, wr_cnt = 0;
  int   eng_bytes = 0, dead_after = -1, eng_left = 0;
  int   stall_idx = -1, stall_left = 0;
  bit   eng_pend = 1'b0, first_start = 1'b0, cs_n_prev = 1'b1, err_prev = 1'b0;
  logic [7:0] eng_cur = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // SPI byte engine: busy from the cycle after start for 1..4 cycles, then returns a planned byte
  always @(negedge clk) begin
    if (rst) begin
      spi_bsy  = 1'b0;
      eng_pend = 1'b0;
      eng_left = 0;
    end else begin
      if (spi_bsy) check("din_stable", spi_din, eng_cur);
      if (spi_start) begin
        check("start_while_busy", spi_bsy, 0);
        start_cyc = cyc;
        eng_bytes++;
        if (first_start) begin
          check("cs_setup_gap", 32'((cyc - fall_cyc) >= CS_GAP), 1);
          first_start = 1'b0;
        end
        if (dead_after >= 0 && eng_bytes > dead_after) begin
          check("start_after_abort", eng_bytes, dead_after + 1);
        end else begin
          eng_pend = 1'b1;
          eng_cur  = spi_din;
          if (exp_mosi.size() == 0) check("unexpected_byte", 1, 0);
          else check("mosi", spi_din, exp_mosi.pop_front());
        end
      end else if (eng_pend) begin
        eng_pend = 1'b0;
        spi_bsy  = 1'b1;
        eng_left = $urandom_range(1, 4);
      end else if (spi_bsy) begin
        eng_left--;
        if (eng_left == 0) begin
          spi_bsy      = 1'b0;
          spi_dout     = (miso_plan.size() != 0) ? miso_plan.pop_front() : 8'h00;
          last_end_cyc = cyc;
        end
      end
    end
  end

  // Write-data source with an optional stall before a given byte index
  always @(negedge clk) begin
    if (stall_left > 0 && wr_cnt == stall_idx) begin
      wdata_valid = 1'b0;
      stall_left--;
    end else begin
      wdata_valid = (wq.size() != 0);
      wdata       = (wq.size() != 0) ? wq[0] : 8'h00;
    end
  end

  always @(posedge clk) begin
    if (!rst && wdata_valid && wdata_ready) begin
      wr_cnt++;
      if (wq.size() != 0) void'(wq.pop_front());
    end
  end

  // Output monitor: read data, done/err, chip-select edges and timing
  always @(negedge clk) begin
    if (!rst) begin
      if (cs_n_prev && !cs_n) begin
        falls++;
        fall_cyc    = cyc;
        first_start = 1'b1;
        check("err_clear_on_accept", err, 0);
      end
      if (!cs_n_prev && cs_n) begin
        rises++;
        check("cs_hold_gap", 32'((cyc - last_end_cyc) >= CS_GAP), 1);
      end
      if (rdata_valid) begin
        if (exp_rdata.size() == 0) check("unexpected_rdata", 1, 0);
        else check("rdata", rdata, exp_rdata.pop_front());
      end
      if (err && !err_prev) check("timeout_latency", cyc - start_cyc, BSY_TO);
      if (done) begin
        if (exp_err.size() == 0) check("unexpected_done", 1, 0);
        else check("done_err", err, exp_err.pop_front());
        check("done_cs_n", cs_n, 1);
        check("cs_falls", falls, 1);
        check("cs_rises", rises, 1);
        falls = 0;
        rises = 0;
        done_seen++;
      end
    end
    cs_n_prev = cs_n;
    err_prev  = err;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs_n"}, cs_n, 1);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_spi_start"}, spi_start, 0);
    check({tag, "_spi_din"}, spi_din, 0);
    check({tag, "_wdata_ready"}, wdata_ready, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_rdata_valid"}, rdata_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic wait_accept(input string tag);
    bit got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(posedge clk);
      if (cmd_valid && cmd_ready) got = 1'b1;
    end
    check({tag, "_accept"}, got, 1);
  endtask

  // Reference model: expected MOSI stream, read data, error and wdata consumption per command
  task automatic run_txn(input logic [7:0] op, input logic [31:0] ad, input bit ua,
                         input int wl, input int rl, input int st_idx, input int st_len,
                         input int dead, input bit keep);
    int a, total, k, nw_exp, target;
    logic [7:0] b, r;
    a     = ua ? ADDR_BYTES : 0;
    total = 1 + a + wl + rl;
    k     = (dead < 0) ? total : dead;
    for (int i = 0; i < total; i++) begin
      if (i == 0) b = op;
      else if (i < 1 + a) b = 8'((ad >> (8 * (a - i))) & 32'hFF);
      else if (i < 1 + a + wl) begin
        b = 8'($urandom);
        wq.push_back(b);
      end else b = 8'hFF;
      if (i < k) begin
        r = 8'($urandom);
        exp_mosi.push_back(b);
        miso_plan.push_back(r);
        if (i >= 1 + a + wl) exp_rdata.push_back(r);
      end
    end
    if (dead < 0) nw_exp = wl;
    else begin
      nw_exp = k + 1 - (1 + a);
      if (nw_exp < 0) nw_exp = 0;
      if (nw_exp > wl) nw_exp = wl;
    end
    exp_err.push_back(dead >= 0);
    wr_cnt     = 0;
    stall_idx  = st_idx;
    stall_left = st_len;
    dead_after = dead;
    if (!keep) eng_bytes = 0;
    target = done_seen + 1;

    opcode    = op;
    addr      = ad;
    use_addr  = ua;
    wr_len    = LEN_W'(wl);
    rd_len    = LEN_W'(rl);
    cmd_valid = 1'b1;
    wait_accept("txn");
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    for (int c = 0; c < 3000 && done_seen < target; c++) @(negedge clk);
    check("done_reached", 32'(done_seen >= target), 1);
    check("wdata_ready_count", wr_cnt, nw_exp);
    check("mosi_drained", exp_mosi.size(), 0);
    check("rdata_drained", exp_rdata.size(), 0);
    wq.delete();
    miso_plan.delete();
    stall_left = 0;
    stall_idx  = -1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; opcode = 0; addr = 0; use_addr = 0;
    wr_len = 0; rd_len = 0; wdata = 0; wdata_valid = 0; spi_bsy = 0; spi_dout = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);

    // Opcode-only, read with address, write with stall
    run_txn(8'h06, 32'h0, 1'b0, 0, 0, -1, 0, -1, 1'b0);
    run_txn(8'h03, 32'h012345, 1'b1, 0, 4, -1, 0, -1, 1'b0);
    run_txn(8'h02, 32'h000100, 1'b1, 3, 0, 1, 20, -1, 1'b0);

    // Dead engine from the first byte, then a clean command clears err
    run_txn(8'h05, 32'h0, 1'b0, 0, 1, -1, 0, 0, 1'b0);
    run_txn(8'h06, 32'h0, 1'b0, 0, 0, -1, 0, -1, 1'b0);
    // Engine dies on the second write byte
    run_txn(8'h02, 32'h00ABCD12, 1'b1, 4, 2, -1, 0, 5, 1'b0);
    run_txn(8'h9F, 32'h0, 1'b0, 0, 3, -1, 0, -1, 1'b0);

    // Reset while the second address byte is in flight
    eng_bytes  = 0;
    dead_after = -1;
    exp_mosi.push_back(8'h0B); exp_mosi.push_back(8'hAB); exp_mosi.push_back(8'hCD);
    for (int i = 0; i < 3; i++) miso_plan.push_back(8'($urandom));
    opcode = 8'h0B; addr = 32'h00ABCDEF; use_addr = 1'b1; wr_len = 0; rd_len = 2;
    cmd_valid = 1'b1;
    wait_accept("rst_txn");
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 500 && eng_bytes < 3; c++) @(negedge clk);
    check("reached_addr_byte2", eng_bytes, 3);
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    exp_mosi.delete(); exp_rdata.delete(); miso_plan.delete(); exp_err.delete(); wq.delete();
    repeat (3) @(negedge clk);
    falls = 0; rises = 0; first_start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_mid_rst", cmd_ready, 1);
    run_txn(8'h0B, 32'h00ABCDEF, 1'b1, 0, 2, -1, 0, -1, 1'b0);

    // Back-to-back with cmd_valid held high
    run_txn(8'h06, 32'h0, 1'b0, 0, 0, -1, 0, -1, 1'b1);
    run_txn(8'h02, 32'h00123456, 1'b1, 2, 0, -1, 0, -1, 1'b1);
    run_txn(8'h03, 32'h00FEDCBA, 1'b1, 0, 2, -1, 0, -1, 1'b0);

    // Randomized commands
    for (int t = 0; t < 12; t++) begin
      int wl, rl, si, sl;
      wl = $urandom_range(0, 5);
      rl = $urandom_range(0, 5);
      si = (wl > 1) ? $urandom_range(0, wl - 1) : -1;
      sl = $urandom_range(0, 6);
      run_txn(8'($urandom), $urandom, 1'($urandom_range(0, 1)), wl, rl, si, sl, -1,
              1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("no_stray_done", exp_err.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
